debug_unit: RTL and testbench
=============================

DEBUG_UNIT -- requirements
Module: debug_unit

Interface
REQ-001 SHALL have parameter NB_INSTRUCTION, default 32, instruction word width.
REQ-002 SHALL have parameter IMEM_ADDR_WIDTH, default 8, instruction-memory byte-address width.
REQ-003 SHALL have parameter NB_BYTE, default 8, received byte width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port i_rx_data  input  NB_BYTE  byte from UART receiver.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe, i_rx_data valid this cycle.
REQ-008 SHALL have port o_imem_data  output  NB_INSTRUCTION  word to instruction memory.
REQ-009 SHALL have port o_imem_waddr  output  IMEM_ADDR_WIDTH  byte write address.
REQ-010 SHALL have port o_mem_wsize  output  2  write size, constant 2'b10 (word).
REQ-011 SHALL have port o_imem_wen  output  1  one-cycle instruction-memory write strobe.
REQ-012 SHALL have port o_cpu_en  output  1  CPU core clock-enable.
REQ-013 SHALL have port o_cpu_rst  output  1  one-cycle CPU core reset pulse.
REQ-014 SHALL have port o_busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, LOAD_CNT, LOAD_DATA, RUN, STEP; all outputs registered.
REQ-016 SHALL, in IDLE, act on accepted bytes only: 0x4C 'L' -> LOAD_CNT; 0x52 'R' -> RUN; 0x53 'S' -> STEP; 0x58 'X' -> o_cpu_rst pulse, stay IDLE; any other byte ignored.
REQ-017 SHALL, in LOAD_CNT, take the next accepted byte as word count N; N=0 -> IDLE with no writes; otherwise clear byte index and address to 0, go LOAD_DATA.
REQ-018 SHALL, in LOAD_DATA, assemble bytes little-endian (first byte -> bits [7:0], fourth -> [31:24]).
REQ-019 SHALL assert o_imem_wen for exactly one cycle, the cycle after the fourth byte of a word is accepted, with o_imem_data = assembled word and o_imem_waddr = current address.
REQ-020 SHALL increment address by 4 after each write, wrapping modulo 2^IMEM_ADDR_WIDTH.
REQ-021 SHALL return to IDLE on the cycle o_imem_wen is asserted for word N.
REQ-022 SHALL hold o_cpu_en=0 in IDLE, LOAD_CNT, LOAD_DATA; all bytes in LOAD states are data, never commands.
REQ-023 SHALL hold o_cpu_en=1 throughout RUN; 0x48 'H' -> IDLE (o_cpu_en=0 next cycle); 'X' -> o_cpu_rst pulse, o_cpu_en=0, IDLE; other bytes ignored.
REQ-024 SHALL, in STEP, assert o_cpu_en for exactly one cycle, then return to IDLE; a byte accepted during the STEP cycle is dropped.
REQ-025 SHALL pulse o_cpu_rst one cycle, the cycle after 'X' is accepted, simultaneous with o_cpu_en=0.
REQ-026 SHALL hold o_imem_data and o_imem_waddr stable between writes; o_imem_wen low except per REQ-019.

Reset
REQ-027 SHALL, while i_rst=1, force state IDLE, o_imem_data=0, o_imem_waddr=0, o_mem_wsize=2'b10, o_imem_wen=0, o_cpu_en=0, o_cpu_rst=0, o_busy=0, byte index=0, count=0.
REQ-028 SHALL abort any load or run when reset is asserted mid-operation; partial words are discarded and not written.
REQ-029 SHALL ignore i_rx_valid in a cycle where i_rst=1.

Verification
REQ-030 Load: 'L',0x02,0x13,0x00,0x00,0x00,0xEF,0xBE,0xAD,0xDE -> writes 0x00000013@0x00 then 0xDEADBEEF@0x04, one wen cycle each, o_busy falls with second wen.
REQ-031 Run/halt: 'R' -> o_cpu_en=1 next cycle, held for 100 cycles with idle rx; 'H' -> o_cpu_en=0 next cycle, o_busy=0.
REQ-032 Step and reset: 'S' -> o_cpu_en high exactly 1 cycle; 'X' during RUN -> o_cpu_rst 1-cycle pulse, o_cpu_en=0, state IDLE.
REQ-033 Data-not-command: 'L',0x01,0x52,0x48,0x58,0x53 -> single write 0x53584852@0x00, o_cpu_en never asserted, no o_cpu_rst.
REQ-034 Wrap and abort: 'L',0x41 with 65 words -> 65th write at address 0x00; separate run: i_rst after 2 of 4 bytes -> no write, all outputs at reset values, next 'L' starts at 0x00.
REQ-035 Edge: 'L',0x00 -> no wen, IDLE next byte; unknown byte 0x00 in IDLE -> no output change.

Source files
------------

// File: rtl/debug_unit.sv
// UART-driven debug controller: loads program words into instruction memory
// and gates the CPU core clock-enable (run / halt / single-step / reset).
module debug_unit #(
    parameter int NB_INSTRUCTION  = 32,
    parameter int IMEM_ADDR_WIDTH = 8,
    parameter int NB_BYTE         = 8
) (
    input  logic                       clk,
    input  logic                       i_rst,
    input  logic [NB_BYTE-1:0]         i_rx_data,
    input  logic                       i_rx_valid,
    output logic [NB_INSTRUCTION-1:0]  o_imem_data,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_waddr,
    output logic [1:0]                 o_mem_wsize,
    output logic                       o_imem_wen,
    output logic                       o_cpu_en,
    output logic                       o_cpu_rst,
    output logic                       o_busy
);

    localparam int BYTES_PER_WORD = NB_INSTRUCTION / NB_BYTE;
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(BYTES_PER_WORD - 1);
    localparam logic [NB_BYTE-1:0] CMD_LOAD  = NB_BYTE'(8'h4C);
    localparam logic [NB_BYTE-1:0] CMD_RUN   = NB_BYTE'(8'h52);
    localparam logic [NB_BYTE-1:0] CMD_STEP  = NB_BYTE'(8'h53);
    localparam logic [NB_BYTE-1:0] CMD_HALT  = NB_BYTE'(8'h48);
    localparam logic [NB_BYTE-1:0] CMD_RESET = NB_BYTE'(8'h58);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_CNT,
        ST_LOAD_DATA,
        ST_RUN,
        ST_STEP
    } state_t;

    state_t                     r_state;
    logic [NB_INSTRUCTION-1:0]  r_shift;
    logic [IDX_W-1:0]           r_idx;
    logic [NB_BYTE-1:0]         r_count;
    logic [IMEM_ADDR_WIDTH-1:0] r_addr;
    logic [NB_INSTRUCTION-1:0]  r_imem_data;
    logic [IMEM_ADDR_WIDTH-1:0] r_imem_waddr;
    logic                       r_imem_wen;
    logic                       r_cpu_en;
    logic                       r_cpu_rst;
    logic                       r_busy;

    state_t                     w_next_state;
    logic [NB_INSTRUCTION-1:0]  w_next_shift;
    logic [NB_INSTRUCTION-1:0]  w_assembled;
    logic [IDX_W-1:0]           w_next_idx;
    logic [NB_BYTE-1:0]         w_next_count;
    logic [IMEM_ADDR_WIDTH-1:0] w_next_addr;
    logic [NB_INSTRUCTION-1:0]  w_next_imem_data;
    logic [IMEM_ADDR_WIDTH-1:0] w_next_imem_waddr;
    logic                       w_next_imem_wen;
    logic                       w_next_cpu_en;
    logic                       w_next_cpu_rst;
    logic                       w_next_busy;

    // Bytes arrive LSB first, so each new byte enters at the top and the
    // word settles little-endian once the last byte has been shifted in.
    assign w_assembled = {i_rx_data, r_shift[NB_INSTRUCTION-1:NB_BYTE]};

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_next_state      = r_state;
        w_next_shift      = r_shift;
        w_next_idx        = r_idx;
        w_next_count      = r_count;
        w_next_addr       = r_addr;
        w_next_imem_data  = r_imem_data;
        w_next_imem_waddr = r_imem_waddr;
        w_next_imem_wen   = 1'b0;
        w_next_cpu_rst    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_LOAD)       w_next_state = ST_LOAD_CNT;
                    else if (i_rx_data == CMD_RUN)   w_next_state = ST_RUN;
                    else if (i_rx_data == CMD_STEP)  w_next_state = ST_STEP;
                    else if (i_rx_data == CMD_RESET) w_next_cpu_rst = 1'b1;
                end
            end
            ST_LOAD_CNT: begin
                if (i_rx_valid) begin
                    if (i_rx_data == '0) begin
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_count = i_rx_data;
                        w_next_idx   = '0;
                        w_next_addr  = '0;
                        w_next_state = ST_LOAD_DATA;
                    end
                end
            end
            ST_LOAD_DATA: begin
                if (i_rx_valid) begin
                    w_next_shift = w_assembled;
                    if (r_idx == LAST_IDX) begin
                        w_next_imem_wen   = 1'b1;
                        w_next_imem_data  = w_assembled;
                        w_next_imem_waddr = r_addr;
                        w_next_addr       = r_addr + IMEM_ADDR_WIDTH'(BYTES_PER_WORD);
                        w_next_idx        = '0;
                        w_next_count      = r_count - NB_BYTE'(1);
                        if (r_count == NB_BYTE'(1)) w_next_state = ST_IDLE;
                    end else begin
                        w_next_idx = r_idx + IDX_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (i_rx_valid) begin
                    if (i_rx_data == CMD_HALT) begin
                        w_next_state = ST_IDLE;
                    end else if (i_rx_data == CMD_RESET) begin
                        w_next_cpu_rst = 1'b1;
                        w_next_state   = ST_IDLE;
                    end
                end
            end
            // Single cycle of clock-enable; any byte arriving now is dropped.
            ST_STEP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase

        w_next_cpu_en = (w_next_state == ST_RUN) || (w_next_state == ST_STEP);
        w_next_busy   = (w_next_state != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values regardless of statement order.
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_count      <= '0;
            r_addr       <= '0;
            r_imem_data  <= '0;
            r_imem_waddr <= '0;
            r_imem_wen   <= 1'b0;
            r_cpu_en     <= 1'b0;
            r_cpu_rst    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_shift      <= w_next_shift;
            r_idx        <= w_next_idx;
            r_count      <= w_next_count;
            r_addr       <= w_next_addr;
            r_imem_data  <= w_next_imem_data;
            r_imem_waddr <= w_next_imem_waddr;
            r_imem_wen   <= w_next_imem_wen;
            r_cpu_en     <= w_next_cpu_en;
            r_cpu_rst    <= w_next_cpu_rst;
            r_busy       <= w_next_busy;
        end
    end

    assign o_imem_data  = r_imem_data;
    assign o_imem_waddr = r_imem_waddr;
    assign o_mem_wsize  = 2'b10;
    assign o_imem_wen   = r_imem_wen;
    assign o_cpu_en     = r_cpu_en;
    assign o_cpu_rst    = r_cpu_rst;
    assign o_busy       = r_busy;

endmodule

// File: tb/tb_debug_unit.sv
// Scoreboard bench for debug_unit: expected memory writes are queued as bytes
// are driven and popped by a monitor whenever o_imem_wen fires.
module tb_debug_unit;

    logic        clk;
    logic        i_rst;
    logic [7:0]  i_rx_data;
    logic        i_rx_valid;
    logic [31:0] o_imem_data;
    logic [7:0]  o_imem_waddr;
    logic [1:0]  o_mem_wsize;
    logic        o_imem_wen;
    logic        o_cpu_en;
    logic        o_cpu_rst;
    logic        o_busy;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         sb_q[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          en_cycles    = 0;
    int          rst_pulses   = 0;
    int          wen_pulses   = 0;
    logic        prev_wen     = 1'b0;
    logic [31:0] hold_data    = '0;
    logic [7:0]  hold_addr    = '0;

    debug_unit dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_imem_data  (o_imem_data),
        .o_imem_waddr (o_imem_waddr),
        .o_mem_wsize  (o_mem_wsize),
        .o_imem_wen   (o_imem_wen),
        .o_cpu_en     (o_cpu_en),
        .o_cpu_rst    (o_cpu_rst),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic drive(input logic [7:0] b);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge clk);
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [7:0] addr);
        wr_t e;
        e.addr = addr;
        e.data = w;
        sb_q.push_back(e);
        for (int i = 0; i < 4; i++) drive(w[8*i +: 8]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"},  o_imem_data, 0);
        check({tag, "_waddr"}, o_imem_waddr, 0);
        check({tag, "_wsize"}, o_mem_wsize, 2'b10);
        check({tag, "_wen"},   o_imem_wen, 0);
        check({tag, "_en"},    o_cpu_en, 0);
        check({tag, "_rst"},   o_cpu_rst, 0);
        check({tag, "_busy"},  o_busy, 0);
    endtask

    // Write monitor: scoreboard pop, single-cycle strobe, stable outputs between writes.
    always @(negedge clk) begin
        if (i_rst) begin
            hold_data = '0;
            hold_addr = '0;
            prev_wen  = 1'b0;
        end else begin
            if (o_cpu_en)  en_cycles++;
            if (o_cpu_rst) rst_pulses++;
            if (o_imem_wen) begin
                wen_pulses++;
                check("wen_one_cycle", prev_wen, 0);
                if (sb_q.size() == 0) begin
                    check("unexpected_wen", 1, 0);
                end else begin
                    wr_t e;
                    e = sb_q.pop_front();
                    check("wr_addr", o_imem_waddr, e.addr);
                    check("wr_data", o_imem_data, e.data);
                    hold_data = e.data;
                    hold_addr = e.addr;
                end
            end else begin
                check("hold_data", o_imem_data, hold_data);
                check("hold_addr", o_imem_waddr, hold_addr);
            end
            prev_wen = o_imem_wen;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en0, rst0, wen0;
        logic [31:0] w;

        i_rst      = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        idle(3);
        check_reset_outputs("reset");
        i_rst = 1'b0;
        idle(2);

        // Unknown byte in IDLE, then zero-length load.
        drive(8'h00);
        check("unk_busy", o_busy, 0);
        check("unk_en", o_cpu_en, 0);
        check("unk_rst", o_cpu_rst, 0);
        drive(8'h4C);
        check("l0_busy_after_L", o_busy, 1);
        drive(8'h00);
        check("l0_busy_after_cnt", o_busy, 0);
        drive(8'h53);
        check("l0_next_is_cmd", o_cpu_en, 1);
        idle(2);

        // Two-word load.
        wen0 = wen_pulses;
        drive(8'h4C);
        drive(8'h02);
        send_word(32'h0000_0013, 8'h00);
        check("load_busy_mid", o_busy, 1);
        send_word(32'hDEAD_BEEF, 8'h04);
        check("load_wen_last", o_imem_wen, 1);
        check("load_busy_falls", o_busy, 0);
        idle(2);
        check("load_wen_count", wen_pulses - wen0, 2);

        // Run for 100 cycles then halt.
        drive(8'h52);
        check("run_en", o_cpu_en, 1);
        check("run_busy", o_busy, 1);
        en0 = en_cycles;
        for (int i = 0; i < 99; i++) @(negedge clk);
        check("run_en_held", en_cycles - en0, 99);
        check("run_en_still", o_cpu_en, 1);
        drive(8'h48);
        check("halt_en", o_cpu_en, 0);
        check("halt_busy", o_busy, 0);
        idle(2);

        // Single step; a byte in the STEP cycle is dropped.
        en0 = en_cycles;
        drive(8'h53);
        check("step_en", o_cpu_en, 1);
        drive(8'h52);
        check("step_en_drop", o_cpu_en, 0);
        check("step_busy", o_busy, 0);
        idle(3);
        check("step_en_cycles", en_cycles - en0, 1);

        // Reset command in IDLE and during RUN.
        drive(8'h58);
        check("x_idle_rst", o_cpu_rst, 1);
        check("x_idle_busy", o_busy, 0);
        idle(1);
        check("x_idle_rst_off", o_cpu_rst, 0);
        drive(8'h52);
        idle(3);
        drive(8'h58);
        check("x_run_rst", o_cpu_rst, 1);
        check("x_run_en", o_cpu_en, 0);
        check("x_run_busy", o_busy, 0);
        idle(1);
        check("x_run_rst_off", o_cpu_rst, 0);
        drive(8'h53);
        check("x_run_idle_after", o_cpu_en, 1);
        idle(2);

        // Command bytes inside a load are data.
        en0  = en_cycles;
        rst0 = rst_pulses;
        drive(8'h4C);
        drive(8'h01);
        send_word(32'h5358_4852, 8'h00);
        idle(3);
        check("dnc_no_en", en_cycles - en0, 0);
        check("dnc_no_rst", rst_pulses - rst0, 0);
        check("dnc_busy", o_busy, 0);

        // 65 words: address wraps to 0x00 on the last one.
        drive(8'h4C);
        drive(8'h41);
        for (int i = 0; i < 65; i++) begin
            w = $urandom;
            send_word(w, 8'((i * 4) % 256));
        end
        check("wrap_last_addr", o_imem_waddr, 8'h00);
        check("wrap_busy", o_busy, 0);
        idle(2);

        // Abort mid-word with reset; rx traffic during reset is ignored.
        wen0 = wen_pulses;
        drive(8'h4C);
        drive(8'h01);
        drive(8'hAA);
        drive(8'hBB);
        i_rst      = 1'b1;
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h4C;
        @(negedge clk);
        check_reset_outputs("abort");
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        @(negedge clk);
        i_rst = 1'b0;
        idle(3);
        check("abort_no_wen", wen_pulses - wen0, 0);
        check("abort_busy", o_busy, 0);
        drive(8'h4C);
        drive(8'h01);
        send_word(32'h1234_5678, 8'h00);
        idle(3);

        check("sb_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
